s3_chien_forney: RTL and testbench



---
 rtl/rs_pkg.sv | 32 +++
 rtl/s3_chien_forney_if.sv | 26 ++
 rtl/gf2m8_multi.sv | 23 ++
 rtl/s3_chien_forney_inv.sv | 29 ++
 rtl/s3_chien_forney.sv | 137 +++++++++++++
 tb/tb_s3_chien_forney.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared GF(2^8) constants, state encoding and constant multipliers for the RS(255,251) decoder
// Contents: field constants (0x11D, alpha and its inverses), default codeword length,
// Chien/Forney state encoding, fixed XOR-network multipliers by alpha, alpha^-1, alpha^-2.
package rs_pkg;

    localparam logic [8:0] GF_POLY       = 9'h11D;
    localparam logic [7:0] GF_ALPHA      = 8'h02;
    localparam logic [7:0] GF_ALPHA_INV  = 8'h8E;
    localparam logic [7:0] GF_ALPHA_INV2 = 8'h47;
    localparam int         RS_N_DEFAULT  = 255;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } cs_state_e;

    // x * alpha: shift up, fold the overflow bit back with the low byte of the polynomial
    function automatic logic [7:0] gf_mul_alpha(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    // x * alpha^-1: alpha^-1 = 0x8E is (0x11D >> 1), so an odd operand folds in 0x8E after the shift
    function automatic logic [7:0] gf_mul_alpha_inv(input logic [7:0] a);
        return {1'b0, a[7:1]} ^ (a[0] ? GF_ALPHA_INV : 8'h00);
    endfunction

    // x * alpha^-2 (= x * 0x47): two alpha^-1 steps, still a pure XOR network
    function automatic logic [7:0] gf_mul_alpha_inv2(input logic [7:0] a);
        return gf_mul_alpha_inv(gf_mul_alpha_inv(a));
    endfunction

endpackage

// File: rtl/s3_chien_forney_if.sv
// rtl/s3_chien_forney_if.sv - key-equation results in, error locations/magnitudes out
// master: drives kes_done and the lambda/omega coefficients, receives error reports.
// slave : the Chien/Forney stage.
interface s3_chien_forney_if;
    logic       kes_done;
    logic [7:0] rs_lambda0;
    logic [7:0] rs_lambda1;
    logic [7:0] rs_lambda2;
    logic [7:0] rs_omega0;
    logic [7:0] rs_omega1;
    logic       err_valid;
    logic [7:0] err_pos;
    logic [7:0] err_val;
    logic       cs_done;
    logic       cs_fail;

    modport master (
        output kes_done, rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1,
        input  err_valid, err_pos, err_val, cs_done, cs_fail
    );

    modport slave (
        input  kes_done, rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1,
        output err_valid, err_pos, err_val, cs_done, cs_fail
    );
endinterface

// File: rtl/gf2m8_multi.sv
// rtl/gf2m8_multi.sv - combinational general GF(2^8) multiplier, polynomial 0x11D
// Ports: a, b (operands), p (product).
module gf2m8_multi
    import rs_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [14:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ (15'(a) << i);
        end
        // reduce from the top bit down so each fold can only disturb lower bits
        for (int i = 14; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (15'(GF_POLY) << (i - 8));
        end
        p = prod[7:0];
    end
endmodule

// File: rtl/s3_chien_forney_inv.sv
// rtl/s3_chien_forney_inv.sv - gf2m8_inv: combinational GF(2^8) inverse from a 256-entry ROM, 0 maps to 0
// Ports: a (operand), y (inverse).
module gf2m8_inv
    import rs_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    // ROM contents generated at elaboration: walking alpha^i forward and alpha^-i backward
    // pairs every non-zero element with its inverse; entry 0 stays 0.
    function automatic logic [2047:0] build_inv_rom();
        logic [2047:0] rom;
        logic [7:0]    fwd;
        logic [7:0]    bwd;
        rom = '0;
        fwd = 8'h01;
        bwd = 8'h01;
        for (int i = 0; i < 255; i++) begin
            rom[{fwd, 3'b000} +: 8] = bwd;
            fwd = gf_mul_alpha(fwd);
            bwd = gf_mul_alpha_inv(bwd);
        end
        return rom;
    endfunction

    localparam logic [2047:0] INV_ROM = build_inv_rom();

    assign y = INV_ROM[{a, 3'b000} +: 8];
endmodule

// File: rtl/s3_chien_forney.sv
// rtl/s3_chien_forney.sv - RS(255,251) stage 3: Chien search with Forney error magnitudes
// Ports: clk, rstn (async active-low), cf (slave): kes_done + lambda0..2/omega0..1 in;
// err_valid/err_pos/err_val per located error, cs_done/cs_fail at end of sweep.
module s3_chien_forney
    import rs_pkg::*;
#(
    parameter int N = RS_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    s3_chien_forney_if.slave  cf
);
    localparam logic [7:0] D_LAST = 8'(N - 1);

    cs_state_e  state_q, state_d;
    logic [7:0] l0_q, l0_d, w0_q, w0_d, w1_q, w1_d, inv_l1_q, inv_l1_d;
    logic [7:0] t1_q, t1_d, t2_q, t2_d, x_q, x_d, d_q, d_d;
    logic [1:0] root_cnt_q, root_cnt_d, deg_l_q, deg_l_d;
    logic       err_valid_q, err_valid_d, cs_done_q, cs_done_d, cs_fail_q, cs_fail_d;
    logic [7:0] err_pos_q, err_pos_d, err_val_q, err_val_d;

    logic [7:0] inv_l1_in, w0x, mag, sum;
    logic [1:0] root_cnt_next;
    logic       root;

    gf2m8_inv   u_inv  (.a(cf.rs_lambda1), .y(inv_l1_in));
    gf2m8_multi u_mul0 (.a(w0_q), .b(x_q), .p(w0x));
    gf2m8_multi u_mul1 (.a(w0x ^ w1_q), .b(inv_l1_q), .p(mag));

    // sum = Lambda(alpha^-d); the x^1 and x^2 terms are carried pre-scaled in t1/t2
    assign sum           = l0_q ^ t1_q ^ t2_q;
    assign root          = (sum == 8'h00);
    assign root_cnt_next = (root && root_cnt_q != 2'd3) ? root_cnt_q + 2'd1 : root_cnt_q;

    always_comb begin
        state_d     = state_q;
        l0_d        = l0_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        inv_l1_d    = inv_l1_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        x_d         = x_q;
        d_d         = d_q;
        root_cnt_d  = root_cnt_q;
        deg_l_d     = deg_l_q;
        err_valid_d = 1'b0;
        err_pos_d   = err_pos_q;
        err_val_d   = err_val_q;
        cs_done_d   = 1'b0;
        cs_fail_d   = cs_fail_q;
        case (state_q)
            ST_IDLE: begin
                if (cf.kes_done) begin
                    state_d    = ST_SEARCH;
                    l0_d       = cf.rs_lambda0;
                    w0_d       = cf.rs_omega0;
                    w1_d       = cf.rs_omega1;
                    inv_l1_d   = inv_l1_in;
                    t1_d       = cf.rs_lambda1;
                    t2_d       = cf.rs_lambda2;
                    x_d        = 8'h01;
                    d_d        = 8'h00;
                    root_cnt_d = 2'd0;
                    deg_l_d    = (cf.rs_lambda2 != 8'h00) ? 2'd2 :
                                 (cf.rs_lambda1 != 8'h00) ? 2'd1 : 2'd0;
                    cs_fail_d  = 1'b0;
                end
            end
            ST_SEARCH: begin
                t1_d       = gf_mul_alpha_inv(t1_q);
                t2_d       = gf_mul_alpha_inv2(t2_q);
                x_d        = gf_mul_alpha(x_q);
                d_d        = d_q + 8'd1;
                root_cnt_d = root_cnt_next;
                if (root) begin
                    err_valid_d = 1'b1;
                    err_pos_d   = d_q;
                    // inv(0) is 0, so a lambda1 = 0 word reports magnitude 0x00 here
                    err_val_d   = mag;
                end
                if (d_q == D_LAST) begin
                    state_d   = ST_IDLE;
                    cs_done_d = 1'b1;
                    // inv_l1_q is zero exactly when lambda1 was zero
                    cs_fail_d = (root_cnt_next != deg_l_q) ||
                                (inv_l1_q == 8'h00 && root_cnt_next != 2'd0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            l0_q        <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            inv_l1_q    <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            x_q         <= '0;
            d_q         <= '0;
            root_cnt_q  <= '0;
            deg_l_q     <= '0;
            err_valid_q <= 1'b0;
            err_pos_q   <= '0;
            err_val_q   <= '0;
            cs_done_q   <= 1'b0;
            cs_fail_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            l0_q        <= l0_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            inv_l1_q    <= inv_l1_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            x_q         <= x_d;
            d_q         <= d_d;
            root_cnt_q  <= root_cnt_d;
            deg_l_q     <= deg_l_d;
            err_valid_q <= err_valid_d;
            err_pos_q   <= err_pos_d;
            err_val_q   <= err_val_d;
            cs_done_q   <= cs_done_d;
            cs_fail_q   <= cs_fail_d;
        end
    end

    assign cf.err_valid = err_valid_q;
    assign cf.err_pos   = err_pos_q;
    assign cf.err_val   = err_val_q;
    assign cf.cs_done   = cs_done_q;
    assign cf.cs_fail   = cs_fail_q;
endmodule

// File: tb/tb_s3_chien_forney.sv
// tb/tb_s3_chien_forney.sv - bench for s3_chien_forney (N=255 and N=10 instances)
module tb_s3_chien_forney;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    s3_chien_forney_if if_a ();
    s3_chien_forney_if if_b ();

    s3_chien_forney #(.N(255)) dut_a (.clk(clk), .rstn(rstn), .cf(if_a));
    s3_chien_forney #(.N(10))  dut_b (.clk(clk), .rstn(rstn), .cf(if_b));

    logic       sel_b = 1'b0;
    logic       kes = 1'b0;
    logic [7:0] c_l0 = 0, c_l1 = 0, c_l2 = 0, c_w0 = 0, c_w1 = 0;

    assign if_a.kes_done   = kes & ~sel_b;
    assign if_b.kes_done   = kes & sel_b;
    assign if_a.rs_lambda0 = c_l0;
    assign if_a.rs_lambda1 = c_l1;
    assign if_a.rs_lambda2 = c_l2;
    assign if_a.rs_omega0  = c_w0;
    assign if_a.rs_omega1  = c_w1;
    assign if_b.rs_lambda0 = c_l0;
    assign if_b.rs_lambda1 = c_l1;
    assign if_b.rs_lambda2 = c_l2;
    assign if_b.rs_omega0  = c_w0;
    assign if_b.rs_omega1  = c_w1;

    wire       o_ev   = sel_b ? if_b.err_valid : if_a.err_valid;
    wire [7:0] o_pos  = sel_b ? if_b.err_pos   : if_a.err_pos;
    wire [7:0] o_val  = sel_b ? if_b.err_val   : if_a.err_val;
    wire       o_done = sel_b ? if_b.cs_done   : if_a.cs_done;
    wire       o_fail = sel_b ? if_b.cs_fail   : if_a.cs_fail;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: plain GF arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] gpow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e % 255; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        for (int b = 1; b < 256; b++) if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
        return 8'h00;
    endfunction

    logic [7:0] exp_pos[$];
    logic [7:0] exp_val[$];
    logic       exp_fail;

    task automatic model(input logic [7:0] l0, l1, l2, w0, w1, input int n);
        logic [7:0] xi, xd, il1, lam;
        int deg, cnt;
        exp_pos.delete();
        exp_val.delete();
        il1 = ginv(l1);
        for (int d = 0; d < n; d++) begin
            xd  = gpow(d);
            xi  = gpow(255 - d);
            lam = l0 ^ gmul(l1, xi) ^ gmul(l2, gmul(xi, xi));
            if (lam == 8'h00) begin
                exp_pos.push_back(8'(d));
                exp_val.push_back(gmul(gmul(w0, xd) ^ w1, il1));
            end
        end
        deg = (l2 != 0) ? 2 : (l1 != 0) ? 1 : 0;
        cnt = (exp_pos.size() > 3) ? 3 : exp_pos.size();
        exp_fail = (cnt != deg) || (l1 == 0 && cnt != 0);
    endtask

    // ---------------- one word: capture, sweep, compare ----------------
    task automatic run_word(input string nm, input logic [7:0] l0, l1, l2, w0, w1,
                            input logic use_b, input logic mid_kes);
        int n;
        int early;
        logic [7:0] got_pos[$];
        logic [7:0] got_val[$];
        n = use_b ? 10 : 255;
        model(l0, l1, l2, w0, w1, n);
        early = 0;
        @(negedge clk);
        sel_b = use_b;
        c_l0 = l0; c_l1 = l1; c_l2 = l2; c_w0 = w0; c_w1 = w1;
        kes = 1'b1;
        @(posedge clk); #1;
        kes = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            kes = 1'b0;
            if (o_ev) begin
                got_pos.push_back(o_pos);
                got_val.push_back(o_val);
            end
            if (k < n && o_done) early++;
            if (mid_kes && k == 50) begin
                c_l0 = 8'($urandom); c_l1 = 8'($urandom); c_l2 = 8'($urandom);
                c_w0 = 8'($urandom); c_w1 = 8'($urandom);
                kes = 1'b1;
            end
        end
        check_eq({nm, ".done_at_n"}, o_done, 1);
        check_eq({nm, ".early_done"}, early, 0);
        check_eq({nm, ".fail"}, o_fail, exp_fail);
        check_eq({nm, ".err_count"}, got_pos.size(), exp_pos.size());
        for (int i = 0; i < exp_pos.size() && i < got_pos.size(); i++) begin
            check_eq({nm, ".pos"}, got_pos[i], exp_pos[i]);
            check_eq({nm, ".val"}, got_val[i], exp_val[i]);
        end
        @(posedge clk); #1;
        check_eq({nm, ".done_pulse"}, o_done, 0);
        check_eq({nm, ".fail_hold"}, o_fail, exp_fail);
    endtask

    initial begin
        logic [7:0] l0, x1, x2, w0, w1;
        int p, q, dones;
        #12;
        check_eq("rst.a_err_valid", if_a.err_valid, 0);
        check_eq("rst.a_err_pos", if_a.err_pos, 0);
        check_eq("rst.a_err_val", if_a.err_val, 0);
        check_eq("rst.a_cs_done", if_a.cs_done, 0);
        check_eq("rst.a_cs_fail", if_a.cs_fail, 0);
        check_eq("rst.b_cs_done", if_b.cs_done, 0);
        @(negedge clk);
        rstn = 1'b1;

        run_word("one_err_d0", 8'h01, 8'h01, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0);
        run_word("one_err_d1", 8'h01, 8'h02, 8'h00, 8'h37, 8'h00, 1'b0, 1'b0);
        run_word("two_err",    8'h01, 8'h03, 8'h02, 8'h00, 8'h03, 1'b0, 1'b0);
        run_word("l1_zero",    8'h01, 8'h00, 8'h01, 8'h12, 8'h34, 1'b0, 1'b0);
        run_word("clean",      8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 1'b0, 1'b0);
        run_word("short_out",  8'h01, 8'h01, 8'h01, 8'h22, 8'h33, 1'b1, 1'b0);
        run_word("mid_kes",    8'h01, 8'h03, 8'h02, 8'h00, 8'h03, 1'b0, 1'b1);

        // reset during the sweep, just after degree 100 is evaluated
        @(negedge clk);
        sel_b = 1'b0;
        c_l0 = 8'h01; c_l1 = 8'h03; c_l2 = 8'h02; c_w0 = 8'h00; c_w1 = 8'h03;
        kes = 1'b1;
        @(posedge clk); #1;
        kes = 1'b0;
        repeat (101) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("rstmid.err_valid", if_a.err_valid, 0);
        check_eq("rstmid.err_pos", if_a.err_pos, 0);
        check_eq("rstmid.err_val", if_a.err_val, 0);
        check_eq("rstmid.cs_done", if_a.cs_done, 0);
        check_eq("rstmid.cs_fail", if_a.cs_fail, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        dones = 0;
        repeat (260) begin
            @(posedge clk); #1;
            if (if_a.cs_done) dones++;
        end
        check_eq("rstmid.no_done", dones, 0);
        run_word("after_rst", 8'h01, 8'h02, 8'h00, 8'h37, 8'h00, 1'b0, 1'b0);

        for (int it = 0; it < 12; it++) begin
            string nm;
            logic ub;
            ub = (it % 3 == 2);
            l0 = 8'($urandom_range(1, 255));
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            p  = ub ? $urandom_range(0, 12) : $urandom_range(0, 254);
            q  = ub ? $urandom_range(0, 12) : $urandom_range(0, 254);
            if (q == p) q = (p + 1) % 255;
            x1 = gpow(p);
            x2 = gpow(q);
            nm = $sformatf("rnd%0d", it);
            case (it % 4)
                0: run_word(nm, l0, 8'h00, 8'h00, w0, w1, ub, 1'b0);
                1: run_word(nm, l0, gmul(l0, x1), 8'h00, w0, w1, ub, 1'b0);
                2: run_word(nm, l0, gmul(l0, x1 ^ x2), gmul(l0, gmul(x1, x2)), w0, w1, ub, 1'b0);
                default: run_word(nm, 8'($urandom), 8'($urandom), 8'($urandom), w0, w1, ub, 1'b0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
